// File: rtl/mem_traffic_master.sv
// Memory traffic master: writes a pattern over NUM_WORDS words, reads
// them back and checks them.
// Ports:
//   clk, resetL                   clock, async active-low reset
//   start, mode, page,
//   base_addr, seed               pass launch and its parameters
//   req_valid/ready/we/page/
//   addr/wdata                    request channel (valid/ready)
//   rsp_valid, rsp_rdata          read response channel
//   busy, done, pass, timeout,
//   err_count, first_err_addr     status and results
module mem_traffic_master #(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 12,
   parameter int PAGE_W    = 4,
   parameter int NUM_WORDS = 4,
   parameter int STRIDE    = 4,
   parameter int TIMEOUT   = 64,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              resetL,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic [PAGE_W-1:0] page,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [DATA_W-1:0] seed,
   output logic              req_valid,
   input  logic              req_ready,
   output logic              req_we,
   output logic [PAGE_W-1:0] req_page,
   output logic [ADDR_W-1:0] req_addr,
   output logic [DATA_W-1:0] req_wdata,
   input  logic              rsp_valid,
   input  logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [CNT_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   typedef enum logic [2:0] {
      IDLE, WR, RD_REQ, RD_WAIT, FIN
   } state_t;

   localparam int K_W = 13;
   localparam int T_W = $clog2(TIMEOUT) + 1;
   localparam logic [K_W-1:0] LAST  = K_W'(NUM_WORDS - 1);
   localparam logic [T_W-1:0] T_LIM = T_W'(TIMEOUT - 1);

   state_t            state_q, state_d;
   logic [K_W-1:0]    k_q, k_d;
   logic [T_W-1:0]    tmo_q, tmo_d;
   logic [1:0]        mode_q, mode_d;
   logic [PAGE_W-1:0] page_q, page_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [DATA_W-1:0] seed_q, seed_d;
   logic [CNT_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] ferr_q, ferr_d;
   logic              tmo_flag_q, tmo_flag_d;
   logic              pass_q, pass_d;

   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] pat;
   logic [DATA_W-1:0] sum;

   // Address and pattern depend only on held registers and k, so
   // they stay put while a request is stalled.
   always_comb begin
      addr = base_q + ADDR_W'(STRIDE) * ADDR_W'(k_q);
      sum  = seed_q + DATA_W'(k_q);
      pat  = '0;
      unique case (mode_q)
         2'd0: pat = sum;
         2'd1: pat = DATA_W'(1) << (32'(k_q) % DATA_W);
         2'd2: pat = DATA_W'(addr);
         2'd3: pat = ~sum;
         default: pat = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      tmo_d      = tmo_q;
      mode_d     = mode_q;
      page_d     = page_q;
      base_d     = base_q;
      seed_d     = seed_q;
      err_d      = err_q;
      ferr_d     = ferr_q;
      tmo_flag_d = tmo_flag_q;
      pass_d     = pass_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = WR;
               k_d        = '0;
               mode_d     = mode;
               page_d     = page;
               base_d     = base_addr;
               seed_d     = seed;
               err_d      = '0;
               ferr_d     = '0;
               tmo_flag_d = 1'b0;
               pass_d     = 1'b0;
            end
         end
         WR: begin
            if (req_ready) begin
               if (k_q == LAST) begin
                  k_d     = '0;
                  state_d = RD_REQ;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         RD_REQ: begin
            if (req_ready) begin
               state_d = RD_WAIT;
               tmo_d   = '0;
            end
         end
         RD_WAIT: begin
            // A response on the limit cycle wins over the timeout.
            if (rsp_valid) begin
               if (rsp_rdata != pat) begin
                  if (err_q != '1) err_d = err_q + 1'b1;
                  if (err_q == '0) ferr_d = addr;
               end
               if (k_q == LAST) begin
                  state_d = FIN;
               end else begin
                  k_d     = k_q + 1'b1;
                  state_d = RD_REQ;
               end
            end else if (tmo_q == T_LIM) begin
               tmo_flag_d = 1'b1;
               state_d    = FIN;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Resolve pass on entry to FIN so it is valid alongside done.
      if (state_q == RD_WAIT && state_d == FIN)
         pass_d = (err_d == '0) && !tmo_flag_d;
   end

   always_ff @(posedge clk or negedge resetL) begin
      if (!resetL) begin
         state_q    <= IDLE;
         k_q        <= '0;
         tmo_q      <= '0;
         mode_q     <= '0;
         page_q     <= '0;
         base_q     <= '0;
         seed_q     <= '0;
         err_q      <= '0;
         ferr_q     <= '0;
         tmo_flag_q <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         tmo_q      <= tmo_d;
         mode_q     <= mode_d;
         page_q     <= page_d;
         base_q     <= base_d;
         seed_q     <= seed_d;
         err_q      <= err_d;
         ferr_q     <= ferr_d;
         tmo_flag_q <= tmo_flag_d;
         pass_q     <= pass_d;
      end
   end

   assign req_valid      = (state_q == WR) || (state_q == RD_REQ);
   assign req_we         = (state_q == WR);
   assign req_page       = page_q;
   assign req_addr       = addr;
   assign req_wdata      = pat;
   assign busy           = (state_q != IDLE);
   assign done           = (state_q == FIN);
   assign pass           = pass_q;
   assign timeout        = tmo_flag_q;
   assign err_count      = err_q;
   assign first_err_addr = ferr_q;

endmodule

// File: tb/tb_mem_traffic_master.sv
// Directed bench for mem_traffic_master with a behavioural memory.
// Ports: none (drives clock, reset and memory responses itself).
module tb_mem_traffic_master;

   localparam logic [63:0] SEED  = 64'h6cce35d5efa8f8f4;
   localparam logic [63:0] SEED2 = 64'hFFFF_FFFF_FFFF_FFFE;

   logic        clk = 1'b0;
   logic        resetL;
   logic        start;
   logic [1:0]  mode;
   logic [3:0]  page;
   logic [11:0] base_addr;
   logic [63:0] seed;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [3:0]  req_page;
   logic [11:0] req_addr;
   logic [63:0] req_wdata;
   logic        rsp_valid;
   logic [63:0] rsp_rdata;
   logic        busy;
   logic        done;
   logic        pass;
   logic        timeout;
   logic [7:0]  err_count;
   logic [11:0] first_err_addr;

   mem_traffic_master dut (
      .clk(clk), .resetL(resetL), .start(start), .mode(mode),
      .page(page), .base_addr(base_addr), .seed(seed),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_page(req_page),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .busy(busy), .done(done), .pass(pass),
      .timeout(timeout), .err_count(err_count),
      .first_err_addr(first_err_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [3:0]  pg;
      logic [11:0] addr;
      logic [63:0] data;
   } xfer_t;

   xfer_t       log_q[$];
   logic [63:0] mem [4096];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          edge_cnt = 0;
   int          done_cnt = 0;
   int          stall_viol = 0;
   int          acc_edge = 0;
   int          done_edge = 0;
   bit          first_rd = 0;
   bit          rand_ready = 0;
   bit          no_rsp = 0;
   bit          corrupt_en = 0;
   logic [11:0] corrupt_addr = '0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   always @(negedge clk) if (done) done_cnt++;

   // Memory: posted writes, reads answered one cycle after acceptance.
   initial begin : responder
      bit          pend = 0;
      logic [63:0] pend_d = '0;
      bit          p_stall = 0;
      logic        p_we = 0;
      logic [3:0]  p_pg = 0;
      logic [11:0] p_ad = 0;
      logic [63:0] p_wd = 0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      forever begin
         @(negedge clk);
         rsp_valid = pend;
         rsp_rdata = pend_d;
         pend = 0;
         if (p_stall && req_valid &&
             (req_we != p_we || req_pg_ne(p_pg) ||
              req_addr != p_ad || req_wdata != p_wd))
            stall_viol++;
         req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         p_stall = req_valid && !req_ready;
         p_we = req_we;
         p_pg = req_page;
         p_ad = req_addr;
         p_wd = req_wdata;
         if (resetL && req_valid && req_ready) begin
            log_q.push_back('{req_we, req_page, req_addr, req_wdata});
            if (req_we) begin
               mem[req_addr] = req_wdata;
            end else begin
               if (first_rd) begin
                  acc_edge = edge_cnt + 1;
                  first_rd = 0;
               end
               if (!no_rsp) begin
                  pend = 1;
                  pend_d = mem[req_addr];
                  if (corrupt_en && req_addr == corrupt_addr)
                     pend_d[0] = ~pend_d[0];
               end
            end
         end
      end
   end

   function automatic bit req_pg_ne(input logic [3:0] p);
      return req_page != p;
   endfunction

   // Called at a negedge; returns at the negedge after done.
   task automatic run_pass(input logic [1:0] m, input logic [3:0] p,
                           input logic [11:0] b, input logic [63:0] s);
      bit got = 0;
      log_q.delete();
      first_rd = 1;
      mode = m;
      page = p;
      base_addr = b;
      seed = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      for (int i = 0; i < 400 && !got; i++) begin
         if (done) got = 1;
         else @(negedge clk);
      end
      chk("done_seen", 64'(got), 64'd1);
      done_edge = edge_cnt;
      @(negedge clk);
   endtask

   logic [11:0] a_s1 [4];
   logic [11:0] a_s3 [4];

   initial begin
      bit got;
      a_s1 = '{12'h000, 12'h004, 12'h008, 12'h00C};
      a_s3 = '{12'hFF8, 12'hFFC, 12'h000, 12'h004};
      resetL = 1'b0;
      start = 1'b0;
      mode = '0;
      page = '0;
      base_addr = '0;
      seed = '0;
      #1;
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_pass", 64'(pass), 64'd0);
      chk("rst_err", 64'(err_count), 64'd0);
      chk("rst_wdata", req_wdata, 64'd0);
      repeat (3) @(negedge clk);
      resetL = 1'b1;

      // Ideal memory, mode 0.
      run_pass(2'd0, 4'd2, 12'h000, SEED);
      chk("s1_nxfer", 64'(log_q.size()), 64'd8);
      for (int k = 0; k < 4; k++) begin
         chk("s1_waddr", 64'(log_q[k].addr), 64'(a_s1[k]));
         chk("s1_wdata", log_q[k].data, SEED + 64'(k));
         chk("s1_raddr", 64'(log_q[k+4].addr), 64'(a_s1[k]));
      end
      chk("s1_we", 64'(log_q[3].we), 64'd1);
      chk("s1_rd_we", 64'(log_q[4].we), 64'd0);
      chk("s1_page", 64'(log_q[2].pg), 64'd2);
      chk("s1_wd3", log_q[3].data, 64'h6cce35d5efa8f8f7);
      chk("s1_pass", 64'(pass), 64'd1);
      chk("s1_err", 64'(err_count), 64'd0);
      chk("s1_busy_end", 64'(busy), 64'd0);

      // Walking-one pattern with bit 0 flipped at address 8.
      corrupt_en = 1;
      corrupt_addr = 12'h008;
      run_pass(2'd1, 4'd1, 12'h000, 64'd0);
      corrupt_en = 0;
      chk("s2_wd2", log_q[2].data, 64'h4);
      chk("s2_wd3", log_q[3].data, 64'h8);
      chk("s2_err", 64'(err_count), 64'd1);
      chk("s2_ferr", 64'(first_err_addr), 64'h008);
      chk("s2_pass", 64'(pass), 64'd0);
      chk("s2_tmo", 64'(timeout), 64'd0);

      // Address wrap, mode 2 (data = address).
      run_pass(2'd2, 4'd3, 12'hFF8, SEED);
      for (int k = 0; k < 4; k++)
         chk("s3_waddr", 64'(log_q[k].addr), 64'(a_s3[k]));
      chk("s3_wd1", log_q[1].data, 64'hFFC);
      chk("s3_wd3", log_q[3].data, 64'h004);
      chk("s3_pass", 64'(pass), 64'd1);
      chk("s3_err", 64'(err_count), 64'd0);
      chk("s3_ferr", 64'(first_err_addr), 64'd0);

      // Silent memory: read timeout.
      no_rsp = 1;
      run_pass(2'd0, 4'd0, 12'h000, SEED);
      no_rsp = 0;
      chk("s4_latency", 64'(done_edge - acc_edge), 64'd64);
      chk("s4_nxfer", 64'(log_q.size()), 64'd5);
      chk("s4_tmo", 64'(timeout), 64'd1);
      chk("s4_pass", 64'(pass), 64'd0);
      chk("s4_err", 64'(err_count), 64'd0);

      // Random stalls, extra start while busy.
      rand_ready = 1;
      stall_viol = 0;
      done_cnt = 0;
      log_q.delete();
      first_rd = 1;
      mode = 2'd0;
      page = 4'd5;
      base_addr = 12'h100;
      seed = SEED2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      mode = 2'd3;
      seed = 64'd0;
      base_addr = 12'h800;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got = 0;
      for (int i = 0; i < 600 && !got; i++) begin
         if (done) got = 1;
         else @(negedge clk);
      end
      chk("s5_done_seen", 64'(got), 64'd1);
      chk("s5_pass", 64'(pass), 64'd1);
      repeat (12) @(negedge clk);
      rand_ready = 0;
      chk("s5_done_cnt", 64'(done_cnt), 64'd1);
      chk("s5_stall", 64'(stall_viol), 64'd0);
      chk("s5_nxfer", 64'(log_q.size()), 64'd8);
      chk("s5_a0", 64'(log_q[0].addr), 64'h100);
      chk("s5_wd1", log_q[1].data, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("s5_wd2", log_q[2].data, 64'd0);
      chk("s5_wd3", log_q[3].data, 64'd1);
      chk("s5_busy", 64'(busy), 64'd0);

      // Reset in the read phase, then a fresh pass.
      log_q.delete();
      mode = 2'd0;
      page = 4'd7;
      base_addr = 12'h040;
      seed = 64'h10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
         if (req_valid && !req_we && log_q.size() > 4) got = 1;
         else @(negedge clk);
      end
      chk("s6_in_read", 64'(got), 64'd1);
      done_cnt = 0;
      resetL = 1'b0;
      #1;
      chk("s6_valid", 64'(req_valid), 64'd0);
      chk("s6_busy", 64'(busy), 64'd0);
      chk("s6_done", 64'(done), 64'd0);
      chk("s6_addr", 64'(req_addr), 64'd0);
      chk("s6_wdata", req_wdata, 64'd0);
      chk("s6_page", 64'(req_page), 64'd0);
      repeat (3) @(negedge clk);
      chk("s6_no_done", 64'(done_cnt), 64'd0);
      resetL = 1'b1;
      run_pass(2'd0, 4'd7, 12'h040, 64'h10);
      chk("s6_a0", 64'(log_q[0].addr), 64'h040);
      chk("s6_wd0", log_q[0].data, 64'h10);
      chk("s6_nxfer", 64'(log_q.size()), 64'd8);
      chk("s6_pass", 64'(pass), 64'd1);
      chk("s6_done_cnt", 64'(done_cnt), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
